hex_entry_pad: RTL
==================

Name: hex_entry_pad

Overview:
- Human-input counterpart to the on-board seven-segment debug display: the operator keys a 32-bit hex word, one nibble at a time, from four slide switches and three push buttons.
- The word is delivered to the processor side over a valid/ready handshake.
- The current entry is exported so the top level can route it to a sevensegment instance through the existing display mux.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles required before a synchronized button level is accepted (min 1)
DIGITS, 8, hex digits per word; word width is 4*DIGITS

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
btn_digit  input  1  raw push button: shift in sw_nibble
btn_enter  input  1  raw push button: commit entry as a word
btn_clear  input  1  raw push button: discard entry / pending word
sw_nibble  input  4  hex digit from switches, sampled when the digit press acts
word_ready  input  1  consumer accepts word_data this cycle
word_data  output  4*DIGITS  committed word
word_valid  output  1  word_data holds an unaccepted word
entry_value  output  4*DIGITS  digits keyed so far, right-justified
digit_count  output  $clog2(DIGITS+1)  digits keyed, saturates at DIGITS
overflow  output  1  sticky: a digit was keyed while digit_count==DIGITS

Behaviour:
- One clock, clk. Reset is synchronous and active-high.
- Reset values: all outputs 0; sync flops, debounced levels and debounce counters 0; state ENTRY.
- Input conditioning, per button:
  - 2-flop synchronizer.
  - Debounce counter increments while the synchronized level differs from the debounced level and clears otherwise.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level takes the synchronized value and the counter clears.
  - A press pulse is asserted for one cycle on each debounced 0->1 transition; releases produce no pulse.
  - Latency: a clean raw rise updates registers exactly DEBOUNCE_CYCLES+3 clk edges later. A button held down produces exactly one pulse.
- State ENTRY (word_valid=0). Events are handled in this priority order:
  - clear: entry_value=0, digit_count=0, overflow=0. A digit or enter pulse in the same cycle is ignored.
  - digit: entry_value={entry_value[4*DIGITS-5:0], sw_nibble}; digit_count+1, saturating at DIGITS. If digit_count was already DIGITS, overflow<=1 and the oldest digit is lost.
  - enter: word_data<=entry_value (including a digit shifted in the same cycle); word_valid<=1; entry_value, digit_count and overflow cleared; go to HOLD. Enter with digit_count==0 commits word 0.
- State HOLD (word_valid=1):
  - word_data stays stable.
  - Digit and enter pulses are ignored and not queued.
  - word_ready==1: word_valid<=0 on the next edge, go to ENTRY.
  - clear pulse: word_valid<=0, go to ENTRY; word_data keeps its last value.
  - word_ready and clear in the same cycle: treated as an accepted transfer.
- word_ready is ignored in ENTRY.
- Reset asserted mid-debounce or in HOLD: everything returns to reset values on that edge. A pending word is lost and no pulse is generated for a button still held at reset release until it is released and pressed again.

Optional Feature:
HEX_ENTRY_BACKSPACE_EN
- Defined:
  - Adds input btn_back (1 bit, raw), conditioned identically to the other buttons.
  - In ENTRY, a back pulse sets entry_value=entry_value>>4 and decrements digit_count, saturating at 0; overflow is unchanged.
  - Priority: clear > back > digit > enter. Back and digit in the same cycle means only back acts.
  - Ignored in HOLD.
- Undefined: no btn_back port and no backspace logic.

Test Plan:
- DEBOUNCE_CYCLES=4, reset, then raw btn_digit rise with sw_nibble=4'hA, held high -> entry_value=32'h0000000A, digit_count=1 exactly 7 edges after the rise; no further change while held.
- btn_digit toggling every 2 cycles for 20 cycles, then left low -> no press pulse; entry_value stays 0.
- Key digits 1,2,3,4,5,6,7,8,9 -> entry_value=32'h23456789, digit_count=8, overflow=1. Then enter -> word_valid=1, word_data=32'h23456789, entry_value=0, overflow=0.
- HOLD with word_ready=0 for 10 cycles while pressing digit 4'h5 -> word_data unchanged, entry_value=0. Then word_ready=1 for one cycle -> word_valid=0 next edge, state ENTRY.
- Digit (sw_nibble=4'h7) and enter pulses in the same cycle from entry 32'h12 -> word_data=32'h127. In HOLD, clear and word_ready together -> word_valid=0, counted as one accepted transfer.
- With HEX_ENTRY_BACKSPACE_EN: key 4'hC, 4'hD, then back -> entry_value=32'hC, digit_count=1. Back twice more -> entry_value=0, digit_count=0.

Source files
------------

// File: rtl/hex_entry_pad.sv
// Hex word entry from slide switches and debounced push buttons, delivered over valid/ready.
// Optional macro HEX_ENTRY_BACKSPACE_EN adds a debounced backspace button (btn_back).
module hex_entry_pad #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DIGITS          = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         btn_digit,
    input  logic                         btn_enter,
    input  logic                         btn_clear,
`ifdef HEX_ENTRY_BACKSPACE_EN
    input  logic                         btn_back,
`endif
    input  logic [3:0]                   sw_nibble,
    input  logic                         word_ready,
    output logic [4*DIGITS-1:0]          word_data,
    output logic                         word_valid,
    output logic [4*DIGITS-1:0]          entry_value,
    output logic [$clog2(DIGITS+1)-1:0]  digit_count,
    output logic                         overflow
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
`ifdef HEX_ENTRY_BACKSPACE_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif

    typedef enum logic {S_ENTRY, S_HOLD} state_t;

    logic [NB-1:0] raw, sync1, sync2, deb, armed, pulse;
    logic [DW-1:0] cnt [NB];
    logic [1:0]    primed;

    assign raw[0] = btn_digit;
    assign raw[1] = btn_enter;
    assign raw[2] = btn_clear;
`ifdef HEX_ENTRY_BACKSPACE_EN
    assign raw[3] = btn_back;
`endif

    // A button is armed only once it has been seen released after reset,
    // so a button held through reset never produces a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            primed <= '0;
            sync1  <= '0;
            sync2  <= '0;
            deb    <= '0;
            armed  <= '0;
            pulse  <= '0;
            for (int i = 0; i < NB; i++) cnt[i] <= '0;
        end else begin
            primed <= {primed[0], 1'b1};
            sync1  <= raw;
            sync2  <= sync1;
            for (int i = 0; i < NB; i++) begin
                pulse[i] <= 1'b0;
                if (primed[1] && !sync2[i]) armed[i] <= 1'b1;
                if (sync2[i] != deb[i]) begin
                    if (cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                        deb[i]   <= sync2[i];
                        cnt[i]   <= '0;
                        pulse[i] <= sync2[i] & armed[i];
                    end else begin
                        cnt[i] <= cnt[i] + DW'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    logic p_digit, p_enter, p_clear, p_back;
    assign p_digit = pulse[0];
    assign p_enter = pulse[1];
    assign p_clear = pulse[2];
`ifdef HEX_ENTRY_BACKSPACE_EN
    assign p_back  = pulse[3];
`else
    assign p_back  = 1'b0;
`endif

    state_t        state, state_next;
    logic [W-1:0]  entry_next, word_next, shifted;
    logic [CW-1:0] count_next;
    logic          ovf_next, load_word;

    always_ff @(posedge clk) begin
        if (reset) state <= S_ENTRY;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_ENTRY: if (p_enter && !p_clear && !p_back) state_next = S_HOLD;
            S_HOLD:  if (word_ready || p_clear)          state_next = S_ENTRY;
            default: state_next = S_ENTRY;
        endcase
    end

    always_comb begin
        shifted    = {entry_value[W-5:0], sw_nibble};
        entry_next = entry_value;
        count_next = digit_count;
        ovf_next   = overflow;
        load_word  = 1'b0;
        word_next  = p_digit ? shifted : entry_value;
        if (state == S_ENTRY) begin
            if (p_clear) begin
                entry_next = '0;
                count_next = '0;
                ovf_next   = 1'b0;
            end
`ifdef HEX_ENTRY_BACKSPACE_EN
            else if (p_back) begin
                entry_next = entry_value >> 4;
                if (digit_count != '0) count_next = digit_count - CW'(1);
            end
`endif
            else begin
                if (p_digit) begin
                    entry_next = shifted;
                    if (digit_count == CW'(DIGITS)) ovf_next   = 1'b1;
                    else                            count_next = digit_count + CW'(1);
                end
                if (p_enter) begin
                    load_word  = 1'b1;
                    entry_next = '0;
                    count_next = '0;
                    ovf_next   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_data   <= '0;
            entry_value <= '0;
            digit_count <= '0;
            overflow    <= 1'b0;
        end else begin
            if (load_word) word_data <= word_next;
            entry_value <= entry_next;
            digit_count <= count_next;
            overflow    <= ovf_next;
        end
    end

    assign word_valid = (state == S_HOLD);

endmodule
